opimm_issue_queue: RTL and testbench
====================================

OPIMM_ISSUE_QUEUE -- requirements
Module: opimm_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, 2..16.
REQ-002 SHALL have port core_clock_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port core_reset_n_i, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port core_flush_i, input, 1, synchronous pipeline flush.
REQ-005 SHALL have port in_valid_i, input, 1, decoded OP-IMM packet present.
REQ-006 SHALL have port in_ready_o, output, 1, queue accepts the packet this cycle.
REQ-007 SHALL have port in_uop_i, input, 7, micro-op code from the OP-IMM decoder.
REQ-008 SHALL have port in_legal_i, input, 1, decoder valid flag; 0 means illegal encoding.
REQ-009 SHALL have port in_sc_i, input, 1, 1 routes to complex unit, 0 to simple ALU.
REQ-010 SHALL have port in_rd_i / in_rs1_i, input, 6 each, physical destination / source.
REQ-011 SHALL have port in_imm_i, input, 12, immediate; in_pc_i, input, 32, instruction PC.
REQ-012 SHALL have ports alu_valid_o / cplx_valid_o, output, 1 each; alu_ready_i / cplx_ready_i, input, 1 each.
REQ-013 SHALL have ports out_uop_o 7, out_rd_o 6, out_rs1_o 6, out_imm_o 12, all outputs, showing the head entry.
REQ-014 SHALL have ports exc_valid_o, output, 1, and exc_pc_o, output, 32, illegal-instruction report.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-016 SHALL be an in-order circular FIFO: write pointer, read pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-017 SHALL drive in_ready_o = (count < DEPTH) and not exc_valid_o and not core_flush_i; no same-cycle full bypass.
REQ-018 SHALL accept a packet on in_valid_i and in_ready_o; legal packets (in_legal_i=1) are written at wptr with their sc bit, count+1.
REQ-019 SHALL not enqueue an accepted illegal packet; it sets exc_valid_o=1 and latches exc_pc_o=in_pc_i next cycle.
REQ-020 SHALL hold exc_valid_o and exc_pc_o until core_flush_i; in_ready_o stays 0 meanwhile; already-queued entries keep draining.
REQ-021 SHALL assert alu_valid_o = (count>0) and not head.sc; cplx_valid_o = (count>0) and head.sc; never both.
REQ-022 SHALL dequeue the head on (alu_valid_o and alu_ready_i) or (cplx_valid_o and cplx_ready_i); rptr+1, count-1.
REQ-023 SHALL permit enqueue and dequeue in the same cycle when count<DEPTH; count unchanged, both pointers advance.
REQ-024 SHALL keep head output fields stable while a valid output is not accepted.
REQ-025 SHALL, on core_flush_i, next cycle set count=0, pointers=0, exc_valid_o=0, discarding any same-cycle enqueue or dequeue.
REQ-026 SHALL make out_* fields don't-care when count=0; both valids 0.
REQ-027 SHALL have zero-cycle output latency from head register: written entry visible at outputs the cycle after acceptance.

Reset
REQ-028 SHALL, on core_reset_n_i low, immediately clear count, wptr, rptr, exc_valid_o, exc_pc_o to 0; alu_valid_o=cplx_valid_o=0; in_ready_o=1 after release.
REQ-029 SHALL abort any in-flight handshake when reset asserts mid-operation; no packet survives reset.

Verification
REQ-030 Fill: DEPTH=4, 4 legal sc=0 packets, alu_ready_i=0 -> count_o=4, in_ready_o=0, alu_valid_o=1, head uop = first packet.
REQ-031 Routing: enqueue uop 0x00 sc=0 then 0x6C sc=1, both readies 1 -> cycle1 alu_valid_o with 0x00, cycle2 cplx_valid_o with 0x6C.
REQ-032 Simultaneous: count=3, enqueue + ALU dequeue same cycle -> count stays 3; count=4 with dequeue -> in_ready_o still 0.
REQ-033 Illegal: in_legal_i=0, in_pc_i=0x00001004 -> exc_valid_o=1, exc_pc_o=0x00001004, in_ready_o=0, count unchanged; core_flush_i -> all cleared.
REQ-034 Wrap: 10 enqueue/dequeue pairs with DEPTH=4 -> outputs emerge in order, no loss, count returns 0.
REQ-035 Reset mid-operation: count=2, assert core_reset_n_i low asynchronously -> valids drop immediately, count_o=0.

Source files
------------

// File: rtl/opimm_issue_queue.sv
// In-order issue queue for decoded OP-IMM packets. Each head entry is routed to the
// simple ALU or the complex unit. An illegal packet is reported and held until a flush.
module opimm_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     core_clock_i,
  input  logic                     core_reset_n_i,
  input  logic                     core_flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [6:0]               in_uop_i,
  input  logic                     in_legal_i,
  input  logic                     in_sc_i,
  input  logic [5:0]               in_rd_i,
  input  logic [5:0]               in_rs1_i,
  input  logic [11:0]              in_imm_i,
  input  logic [31:0]              in_pc_i,
  output logic                     alu_valid_o,
  input  logic                     alu_ready_i,
  output logic                     cplx_valid_o,
  input  logic                     cplx_ready_i,
  output logic [6:0]               out_uop_o,
  output logic [5:0]               out_rd_o,
  output logic [5:0]               out_rs1_o,
  output logic [11:0]              out_imm_o,
  output logic                     exc_valid_o,
  output logic [31:0]              exc_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [6:0]  uop_q [DEPTH];
  logic [5:0]  rd_q  [DEPTH];
  logic [5:0]  rs1_q [DEPTH];
  logic [11:0] imm_q [DEPTH];
  logic        sc_q  [DEPTH];

  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          accept, enq, illegal, deq, not_empty;

  assign not_empty    = (count != '0);
  assign in_ready_o   = (count < CW'(DEPTH)) && !exc_valid_o && !core_flush_i;
  assign accept       = in_valid_i && in_ready_o;
  assign enq          = accept && in_legal_i;
  assign illegal      = accept && !in_legal_i;

  assign alu_valid_o  = not_empty && !sc_q[rptr];
  assign cplx_valid_o = not_empty &&  sc_q[rptr];
  assign deq          = (alu_valid_o && alu_ready_i) || (cplx_valid_o && cplx_ready_i);

  assign out_uop_o    = uop_q[rptr];
  assign out_rd_o     = rd_q[rptr];
  assign out_rs1_o    = rs1_q[rptr];
  assign out_imm_o    = imm_q[rptr];
  assign count_o      = count;

  // Payload storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge core_clock_i) begin
    if (enq) begin
      uop_q[wptr] <= in_uop_i;
      rd_q[wptr]  <= in_rd_i;
      rs1_q[wptr] <= in_rs1_i;
      imm_q[wptr] <= in_imm_i;
      sc_q[wptr]  <= in_sc_i;
    end
  end

  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      exc_valid_o <= 1'b0;
      exc_pc_o    <= '0;
    end else if (core_flush_i) begin
      // Flush wins over any dequeue handshake seen in the same cycle.
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      exc_valid_o <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (illegal) begin
        exc_valid_o <= 1'b1;
        exc_pc_o    <= in_pc_i;
      end
    end
  end

endmodule

// File: tb/tb_opimm_issue_queue.sv
// Bench for opimm_issue_queue (DEPTH=4): a vector table, hand-written corner sequences,
// and a reference queue that every dequeued head is compared against.
module tb_opimm_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0, in_legal = 1'b1, in_sc = 1'b0;
  logic [6:0]  in_uop = '0;
  logic [5:0]  in_rd = '0, in_rs1 = '0;
  logic [11:0] in_imm = '0;
  logic [31:0] in_pc = '0;
  logic        alu_ready = 1'b0, cplx_ready = 1'b0;
  logic        in_ready, alu_valid, cplx_valid, exc_valid;
  logic [6:0]  out_uop;
  logic [5:0]  out_rd, out_rs1;
  logic [11:0] out_imm;
  logic [31:0] exc_pc;
  logic [2:0]  count;

  opimm_issue_queue #(.DEPTH(4)) dut (
    .core_clock_i(clk), .core_reset_n_i(rst_n), .core_flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_uop_i(in_uop),
    .in_legal_i(in_legal), .in_sc_i(in_sc), .in_rd_i(in_rd), .in_rs1_i(in_rs1),
    .in_imm_i(in_imm), .in_pc_i(in_pc),
    .alu_valid_o(alu_valid), .alu_ready_i(alu_ready),
    .cplx_valid_o(cplx_valid), .cplx_ready_i(cplx_ready),
    .out_uop_o(out_uop), .out_rd_o(out_rd), .out_rs1_o(out_rs1), .out_imm_o(out_imm),
    .exc_valid_o(exc_valid), .exc_pc_o(exc_pc), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  uop;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [11:0] imm;
    logic        sc;
  } entry_t;

  typedef struct {
    logic        v, legal, sc;
    logic [6:0]  uop;
    logic        ar, cr, fl;
    logic [31:0] pc;
    int          exp_cnt;
    logic        exp_rdy, exp_exc;
  } vec_t;

  entry_t      sb[$];
  logic        m_exc = 1'b0;
  logic [31:0] m_pc = '0;
  int          checks = 0, failures = 0;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic legal, input logic sc, input logic [6:0] uop,
                       input logic [31:0] pc, input logic ar, input logic cr, input logic fl);
    in_valid = v; in_legal = legal; in_sc = sc; in_uop = uop; in_pc = pc;
    in_rd = uop[5:0] ^ 6'h2A; in_rs1 = uop[6:1]; in_imm = {uop[3:0], uop, sc};
    alu_ready = ar; cplx_ready = cr; flush = fl;
  endtask

  // One clock: compare DUT against the reference queue at the falling edge, then advance it.
  task automatic tick();
    logic exp_rdy, ea, ec;
    entry_t e;
    @(negedge clk);
    exp_rdy = (sb.size() < 4) && !m_exc && !flush;
    ea = (sb.size() > 0) && !sb[0].sc;
    ec = (sb.size() > 0) &&  sb[0].sc;
    check("alu_valid", 32'(alu_valid), 32'(ea));
    check("cplx_valid", 32'(cplx_valid), 32'(ec));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("count", 32'(count), 32'(sb.size()));
    check("exc_valid", 32'(exc_valid), 32'(m_exc));
    if (m_exc) check("exc_pc", exc_pc, m_pc);
    if (flush) begin
      sb.delete();
      m_exc = 1'b0;
    end else begin
      if ((ea && alu_ready) || (ec && cplx_ready)) begin
        e = sb.pop_front();
        check("head_uop", 32'(out_uop), 32'(e.uop));
        check("head_rd", 32'(out_rd), 32'(e.rd));
        check("head_rs1", 32'(out_rs1), 32'(e.rs1));
        check("head_imm", 32'(out_imm), 32'(e.imm));
      end
      if (in_valid && exp_rdy) begin
        if (in_legal) begin
          e.uop = in_uop; e.rd = in_uop[5:0] ^ 6'h2A; e.rs1 = in_uop[6:1];
          e.imm = {in_uop[3:0], in_uop, in_sc}; e.sc = in_sc;
          sb.push_back(e);
        end else begin
          m_exc = 1'b1;
          m_pc  = in_pc;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          v  lg sc uop    ar cr fl pc            cnt rdy  exc
    vecs[0] = '{1, 1, 0, 7'h11, 0, 0, 0, 32'h0,        1,  1,   0};
    vecs[1] = '{1, 1, 0, 7'h12, 0, 0, 0, 32'h0,        2,  1,   0};
    vecs[2] = '{1, 1, 0, 7'h13, 0, 0, 0, 32'h0,        3,  1,   0};
    vecs[3] = '{1, 1, 0, 7'h14, 0, 0, 0, 32'h0,        4,  0,   0};
    vecs[4] = '{1, 1, 0, 7'h15, 1, 0, 0, 32'h0,        3,  1,   0}; // full: dequeue only
    vecs[5] = '{1, 1, 0, 7'h16, 1, 0, 0, 32'h0,        3,  1,   0}; // enq + deq together
    vecs[6] = '{1, 0, 0, 7'h17, 0, 0, 0, 32'h00001004, 3,  0,   1}; // illegal packet
    vecs[7] = '{1, 1, 0, 7'h18, 1, 0, 0, 32'h0,        2,  0,   1}; // blocked, still drains
    vecs[8] = '{0, 1, 0, 7'h00, 1, 0, 1, 32'h0,        0,  1,   0}; // flush

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_valids", 32'({alu_valid, cplx_valid}), 32'd0);
    check("rst_exc", 32'({exc_valid, exc_pc}), 32'd0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].legal, vecs[i].sc, vecs[i].uop, vecs[i].pc,
            vecs[i].ar, vecs[i].cr, vecs[i].fl);
      tick();
      drive(0, 1, 0, 7'h00, 32'h0, 0, 0, 0);
      #1;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_exc", i), 32'(exc_valid), 32'(vecs[i].exp_exc));
      if (i == 3) begin
        check("full_alu_valid", 32'(alu_valid), 32'd1);
        check("full_head_uop", 32'(out_uop), 32'h11);
      end
      if (i == 6) check("exc_pc_latched", exc_pc, 32'h00001004);
    end

    // Routing: ALU packet then complex-unit packet
    drive(1, 1, 0, 7'h00, 32'h0, 1, 1, 0);
    tick();
    drive(1, 1, 1, 7'h6C, 32'h0, 1, 1, 0);
    #1;
    check("route_alu_valid", 32'(alu_valid), 32'd1);
    check("route_alu_uop", 32'(out_uop), 32'h00);
    tick();
    drive(0, 1, 0, 7'h00, 32'h0, 1, 1, 0);
    #1;
    check("route_cplx_valid", 32'(cplx_valid), 32'd1);
    check("route_no_alu", 32'(alu_valid), 32'd0);
    check("route_cplx_uop", 32'(out_uop), 32'h6C);
    tick();
    check("route_empty", 32'(count), 32'd0);

    // Pointer wrap: ten back-to-back enqueue/dequeue pairs
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 32'h0, 1, 1, 0);
      tick();
    end
    drive(0, 1, 0, 7'h00, 32'h0, 1, 1, 0);
    tick();
    check("wrap_count", 32'(count), 32'd0);

    // Random traffic with back-pressure, then a bounded drain
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
            32'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      tick();
    end
    drive(0, 1, 0, 7'h00, 32'h0, 1, 1, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check("drain_done", 32'(sb.size()), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Asynchronous reset with two entries queued
    drive(1, 1, 0, 7'h21, 32'h0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 7'h22, 32'h0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 7'h00, 32'h0, 0, 0, 0);
    check("pre_rst_count", 32'(count), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valids", 32'({alu_valid, cplx_valid}), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    sb.delete();
    m_exc = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
